// File: rtl/vrf_pkg.sv
// vrf_pkg: shared constants, FSM state type and byte helpers for the multi-port vector register file
package vrf_pkg;
   localparam int VRF_DATA_WIDTH = 32;
   localparam int VRF_ADDR_WIDTH = 5;
   localparam int VRF_MAX_WIDTH  = 1024;
   typedef enum logic {VRF_IDLE, VRF_CLEAR} vrf_state_t;
   function automatic int vrf_be_width(input int dw);
      return dw / 8;
   endfunction
   function automatic logic [VRF_MAX_WIDTH-1:0] vrf_merge(input logic [VRF_MAX_WIDTH-1:0] old_w,
                                                          input logic [VRF_MAX_WIDTH-1:0] new_w,
                                                          input logic [VRF_MAX_WIDTH/8-1:0] be);
      logic [VRF_MAX_WIDTH-1:0] r;
      r = old_w;
      for (int i = 0; i < VRF_MAX_WIDTH / 8; i++)
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/vrf_clear_seq.sv
// vrf_clear_seq: zero-sweep sequencer producing the clear write stream and busy
module vrf_clear_seq import vrf_pkg::*; #(
   parameter int ADDR_WIDTH = VRF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;
   vrf_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   // state and sweep index; reset starts a fresh sweep from address 0
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= VRF_CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   // next state: sweep to the last word, then idle until a clear request
   always_comb begin
      state_d = (state_q == VRF_CLEAR) ? ((idx_q == LAST) ? VRF_IDLE : VRF_CLEAR)
                                       : (clr_req ? VRF_CLEAR : VRF_IDLE);
      idx_d   = (state_q == VRF_CLEAR) ? idx_q + 1'b1 : '0;
   end
   assign busy     = (state_q == VRF_CLEAR);
   assign clr_we   = busy;
   assign clr_addr = idx_q;
endmodule

// File: rtl/vector_register_file_mp.sv
// vector_register_file_mp: 1W/2R vector register file with clear sweep; VRF_BYPASS_EN selects write-first collisions
module vector_register_file_mp import vrf_pkg::*; #(
   parameter  int DATA_WIDTH = VRF_DATA_WIDTH,
   parameter  int ADDR_WIDTH = VRF_ADDR_WIDTH,
   localparam int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cs,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd0_en,
   input  logic [ADDR_WIDTH-1:0]   rd0_addr,
   output logic [DATA_WIDTH-1:0]   rd0_data,
   output logic                    rd0_valid,
   input  logic                    rd1_en,
   input  logic [ADDR_WIDTH-1:0]   rd1_addr,
   output logic [DATA_WIDTH-1:0]   rd1_data,
   output logic                    rd1_valid,
   input  logic                    clr_req,
   output logic                    busy
);
   localparam int BE_W = vrf_be_width(DATA_WIDTH);
   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] o,
                                                   input logic [DATA_WIDTH-1:0] n,
                                                   input logic [BE_W-1:0] b);
      return DATA_WIDTH'(vrf_merge(VRF_MAX_WIDTH'(o), VRF_MAX_WIDTH'(n), (VRF_MAX_WIDTH/8)'(b)));
   endfunction
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_act, rd0_act, rd1_act;
   logic [DATA_WIDTH-1:0] wr_word, rd0_word, rd1_word;
   vrf_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );
   assign wr_act  = cs & wr_en & ~busy;
   assign rd0_act = cs & rd0_en & ~busy;
   assign rd1_act = cs & rd1_en & ~busy;
   assign wr_word = merge(mem[wr_addr], wr_data, wr_be);
   // read words; with bypass a colliding write's enabled bytes are forwarded
   always_comb begin
`ifdef VRF_BYPASS_EN
      rd0_word = (wr_act && wr_addr == rd0_addr) ? wr_word : mem[rd0_addr];
      rd1_word = (wr_act && wr_addr == rd1_addr) ? wr_word : mem[rd1_addr];
`else
      rd0_word = mem[rd0_addr];
      rd1_word = mem[rd1_addr];
`endif
   end
   // array write mux: the clear sweep owns the port while busy
   always_ff @(posedge clk)
      if (clr_we) mem[clr_addr] <= '0;
      else if (wr_act) mem[wr_addr] <= wr_word;
   // registered read ports: data holds when idle, valid pulses one cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd0_data  <= '0;
         rd1_data  <= '0;
         rd0_valid <= 1'b0;
         rd1_valid <= 1'b0;
      end else begin
         rd0_data  <= rd0_act ? rd0_word : rd0_data;
         rd1_data  <= rd1_act ? rd1_word : rd1_data;
         rd0_valid <= rd0_act;
         rd1_valid <= rd1_act;
      end
endmodule
